// File: rtl/pack_arb_pkg.sv
// Shared types and constants for the packet-buffer write-port arbiter.
package pack_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } arbState_e;

    localparam int         FRAME_WORDS = 8;
    localparam logic [3:0] HDR_MARK    = 4'hF;
    localparam int         SRC_ID_W    = 4;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pack_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [PTR_W-1:0] pickIdx,
    output logic             anyReq
);

    logic [PTR_W-1:0] candIdx_s;
    logic             found_s;

    // Scan the request vector starting at the pointer and keep the first hit
    always_comb begin
        pick      = '0;
        pickIdx   = '0;
        found_s   = 1'b0;
        candIdx_s = '0;
        for (int off = 0; off < NREQ; off++) begin
            candIdx_s = PTR_W'((int'(ptr) + off) % NREQ);
            if (!found_s && req[candIdx_s]) begin
                found_s         = 1'b1;
                pick[candIdx_s] = 1'b1;
                pickIdx         = candIdx_s;
            end else begin
                found_s = found_s;
            end
        end
        anyReq = |req;
    end

endmodule

// File: rtl/pack_frame_arbiter.sv
// Grants whole 8-word frames of the packet-buffer write port round-robin among NREQ sources.
// Optional PACK_ARB_TAG_EN: arbiter prepends a {mark, src_id, seq} header word to each frame.
module pack_frame_arbiter
    import pack_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               wrClk,
    input  logic               rst,
    input  logic               sync,
    input  logic [NREQ-1:0]    src_valid,
    input  logic [16*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]    src_abort,
    output logic [NREQ-1:0]    src_ready,
    output logic               WdAvail,
    output logic [15:0]        PacketWd,
    output logic               PacketReset,
    output logic [NREQ-1:0]    grant,
    output logic [15:0]        drop_count
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STALL_W = $clog2(TIMEOUT);

    arbState_e          state_r;
    logic [PTR_W-1:0]   rrPtr_r;
    logic [PTR_W-1:0]   ownerIdx_r;
    logic [2:0]         wordCnt_r;
    logic [STALL_W-1:0] stallCnt_r;
`ifdef PACK_ARB_TAG_EN
    logic [7:0]         seq_r;
`endif

    logic [NREQ-1:0]    pick_s;
    logic [PTR_W-1:0]   pickIdx_s;
    logic               anyReq_s;
    logic               accept_s;
    logic               exit_s;
    logic [15:0]        ownerWord_s;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + PTR_W'(1);
    endfunction

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req     (src_valid),
        .ptr     (rrPtr_r),
        .pick    (pick_s),
        .pickIdx (pickIdx_s),
        .anyReq  (anyReq_s)
    );

    // Owner handshake; grant is zero outside STREAM so non-owners never see ready
    always_comb begin
        src_ready   = grant & ~src_abort & {NREQ{sync}};
        ownerWord_s = src_data[{ownerIdx_r, 4'b0000} +: 16];
        accept_s    = src_valid[ownerIdx_r] & src_ready[ownerIdx_r];
        exit_s      = src_abort[ownerIdx_r] | ~sync | (stallCnt_r == STALL_W'(TIMEOUT - 1));
    end

    // Frame sequencer with registered write-port outputs
    always_ff @(posedge wrClk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rrPtr_r     <= '0;
            ownerIdx_r  <= '0;
            wordCnt_r   <= 3'd0;
            stallCnt_r  <= '0;
            WdAvail     <= 1'b0;
            PacketWd    <= 16'h0000;
            PacketReset <= 1'b0;
            grant       <= '0;
            drop_count  <= 16'h0000;
`ifdef PACK_ARB_TAG_EN
            seq_r       <= 8'h00;
`endif
        end else begin
            WdAvail     <= 1'b0;
            PacketReset <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sync && anyReq_s) begin
                        state_r    <= ST_STREAM;
                        grant      <= pick_s;
                        ownerIdx_r <= pickIdx_s;
                        stallCnt_r <= '0;
`ifdef PACK_ARB_TAG_EN
                        WdAvail    <= 1'b1;
                        PacketWd   <= {HDR_MARK, SRC_ID_W'(pickIdx_s), seq_r};
                        wordCnt_r  <= 3'd1;
`else
                        wordCnt_r  <= 3'd0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (accept_s) begin
                        WdAvail    <= 1'b1;
                        PacketWd   <= ownerWord_s;
                        wordCnt_r  <= wordCnt_r + 3'd1;
                        stallCnt_r <= '0;
                        if (wordCnt_r == 3'(FRAME_WORDS - 1)) begin
                            state_r <= ST_IDLE;
                            grant   <= '0;
                            rrPtr_r <= nextPtr(ownerIdx_r);
`ifdef PACK_ARB_TAG_EN
                            seq_r   <= seq_r + 8'd1;
`endif
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else if (exit_s) begin
                        grant      <= '0;
                        wordCnt_r  <= 3'd0;
                        stallCnt_r <= '0;
                        // An empty frame has nothing in the buffer to roll back
                        if (wordCnt_r != 3'd0) begin
                            state_r     <= ST_FLUSH;
                            PacketReset <= 1'b1;
                            drop_count  <= satInc16(drop_count);
                            rrPtr_r     <= nextPtr(ownerIdx_r);
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        stallCnt_r <= stallCnt_r + STALL_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pack_frame_arbiter.sv
// Self-checking bench for pack_frame_arbiter (NREQ=2, TIMEOUT=16): vector table, directed sequences,
// and a randomized phase, all cross-checked each cycle against a frame-level reference model.
module tb_pack_frame_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic        wrClk;
    logic        rst;
    logic        sync;
    logic [1:0]  srcValid;
    logic [31:0] srcData;
    logic [1:0]  srcAbort;
    logic [1:0]  src_ready;
    logic        WdAvail;
    logic [15:0] PacketWd;
    logic        PacketReset;
    logic [1:0]  grant;
    logic [15:0] drop_count;

    int nTests = 0;
    int nFail  = 0;

    pack_frame_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wrClk       (wrClk),
        .rst         (rst),
        .sync        (sync),
        .src_valid   (srcValid),
        .src_data    (srcData),
        .src_abort   (srcAbort),
        .src_ready   (src_ready),
        .WdAvail     (WdAvail),
        .PacketWd    (PacketWd),
        .PacketReset (PacketReset),
        .grant       (grant),
        .drop_count  (drop_count)
    );

    initial wrClk = 1'b0;
    always #5 wrClk = ~wrClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wrClk);
        #1;
        srcData = $urandom;
    endtask

    function automatic int rrPick(input logic [1:0] v, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: frame-level bookkeeping, predicts outputs one cycle ahead
    bit          mArmed = 1'b0;
    int          mOwner = -1;
    bit          mFlush = 1'b0;
    int          mPtr   = 0;
    int          mStall = 0;
    int          mDrops = 0;
    logic [7:0]  mSeq   = 8'h00;
    logic [15:0] frameQ[$];
    logic [1:0]  expGrant = 2'b00;
    logic        expWd    = 1'b0;
    logic        expReset = 1'b0;
    logic [15:0] expWord  = 16'h0000;

    always @(negedge wrClk) begin
        logic [1:0] expReady;
        int g;
        if (mArmed) begin
            expReady = (mOwner >= 0) ? (2'(1 << mOwner) & ~srcAbort & {2{sync}}) : 2'b00;
            check("m_grant", 32'(grant), 32'(expGrant));
            check("m_src_ready", 32'(src_ready), 32'(expReady));
            check("m_WdAvail", 32'(WdAvail), 32'(expWd));
            if (expWd) check("m_PacketWd", 32'(PacketWd), 32'(expWord));
            check("m_PacketReset", 32'(PacketReset), 32'(expReset));
            check("m_drop_count", 32'(drop_count), 32'(mDrops));
        end
        expWd    = 1'b0;
        expReset = 1'b0;
        if (rst) begin
            mArmed = 1'b1; mOwner = -1; mFlush = 1'b0; mPtr = 0; mDrops = 0; mSeq = 8'h00;
            frameQ.delete();
            expGrant = 2'b00;
        end else if (mFlush) begin
            mFlush   = 1'b0;
            expGrant = 2'b00;
        end else if (mOwner < 0) begin
            expGrant = 2'b00;
            if (sync && srcValid != 2'b00) begin
                mOwner   = rrPick(srcValid, mPtr);
                expGrant = 2'(1 << mOwner);
                mStall   = 0;
                frameQ.delete();
`ifdef PACK_ARB_TAG_EN
                expWd   = 1'b1;
                expWord = {4'hF, 4'(mOwner), mSeq};
                frameQ.push_back(expWord);
`endif
            end
        end else begin
            g = mOwner;
            if (srcValid[g] && !srcAbort[g] && sync) begin
                expWd   = 1'b1;
                expWord = srcData[16*g +: 16];
                frameQ.push_back(expWord);
                mStall  = 0;
                if (frameQ.size() == 8) begin
                    mOwner   = -1;
                    mPtr     = (g + 1) % NREQ;
                    mSeq     = mSeq + 8'd1;
                    expGrant = 2'b00;
                end
            end else begin
                mStall++;
                if (srcAbort[g] || !sync || mStall >= TIMEOUT) begin
                    if (frameQ.size() > 0) begin
                        expReset = 1'b1;
                        mDrops   = (mDrops == 65535) ? mDrops : mDrops + 1;
                        mFlush   = 1'b1;
                        mPtr     = (g + 1) % NREQ;
                    end
                    mOwner   = -1;
                    expGrant = 2'b00;
                    frameQ.delete();
                end
            end
        end
    end

    typedef struct {
        logic       sync;
        logic [1:0] valid;
        logic [1:0] expGrant;
    } vec_t;

    vec_t        vecs[6];
    logic [1:0]  ownerLog[4];
    logic [1:0]  quiet;
    logic [1:0]  prevG;
    logic [1:0]  gsum;
    logic [15:0] hdr[3];
    int          rises, wdCnt, pr, nh;

    initial begin
        rst = 1'b1; sync = 1'b0; srcValid = 2'b00; srcAbort = 2'b00; srcData = 32'h0; quiet = 2'b00;
        vecs[0] = '{1'b0, 2'b11, 2'b00};
        vecs[1] = '{1'b1, 2'b00, 2'b00};
        vecs[2] = '{1'b1, 2'b01, 2'b01};
        vecs[3] = '{1'b1, 2'b10, 2'b10};
        vecs[4] = '{1'b1, 2'b11, 2'b01};
        vecs[5] = '{1'b1, 2'b11, 2'b01};
        foreach (ownerLog[i]) ownerLog[i] = 2'b00;
        foreach (hdr[i]) hdr[i] = 16'h0000;

        tick(); tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_WdAvail", 32'(WdAvail), 32'h0);
        check("rst_PacketReset", 32'(PacketReset), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        rst = 1'b0;
        tick();

        // Vector table: pick from IDLE, then owner aborts with nothing written
        for (int i = 0; i < 6; i++) begin
            sync = vecs[i].sync; srcValid = vecs[i].valid; srcAbort = 2'b00;
            tick();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].expGrant));
            sync = 1'b1; srcValid = 2'b00; srcAbort = 2'b11;
            tick();
            check($sformatf("vec%0d_noreset", i), 32'(PacketReset), 32'h0);
            check($sformatf("vec%0d_released", i), 32'(grant), 32'h0);
            srcAbort = 2'b00;
        end
        check("vec_drop_count", 32'(drop_count), 32'h0);

        // Both sources streaming: frames alternate, 8 writes each
        sync = 1'b1; srcValid = 2'b11; rises = 0; wdCnt = 0; prevG = grant;
        for (int c = 0; c < 80 && rises < 4; c++) begin
            tick();
            if (WdAvail) wdCnt++;
            if (grant != 2'b00 && prevG == 2'b00) begin
                ownerLog[rises] = grant;
                if (rises > 0) check("t1_frame_len", 32'(wdCnt), 32'd8);
                wdCnt = 0;
                rises++;
            end
            prevG = grant;
        end
        check("t1_owner0", 32'(ownerLog[0]), 32'h1);
        check("t1_owner1", 32'(ownerLog[1]), 32'h2);
        check("t1_owner2", 32'(ownerLog[2]), 32'h1);
        check("t1_owner3", 32'(ownerLog[3]), 32'h2);

        // Reset in the middle of a src1 frame
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t5_grant", 32'(grant), 32'h0);
        check("t5_WdAvail", 32'(WdAvail), 32'h0);
        check("t5_PacketReset", 32'(PacketReset), 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 10 && grant == 2'b00; c++) tick();
        check("t5_first_grant", 32'(grant), 32'h1);

        // src0 stalls after 3 words until timeout
        wdCnt = 0;
        for (int c = 0; c < 20 && wdCnt < 3; c++) begin
            tick();
            if (WdAvail) wdCnt++;
        end
        srcValid[0] = 1'b0;
        pr = 0;
        for (int c = 0; c < TIMEOUT + 10 && grant != 2'b10; c++) begin
            tick();
            if (PacketReset) pr++;
        end
        check("t2_resets", 32'(pr), 32'd1);
        check("t2_drop_count", 32'(drop_count), 32'd1);
        check("t2_next_grant", 32'(grant), 32'h2);

        // src1 aborts with valid on its 5th word
        wdCnt = 0; pr = 0;
        for (int c = 0; c < 20 && wdCnt < 4; c++) begin
            tick();
            if (WdAvail) wdCnt++;
        end
        srcAbort[1] = 1'b1;
        for (int c = 0; c < 10 && pr == 0; c++) begin
            tick();
            if (WdAvail) wdCnt++;
            if (PacketReset) pr++;
        end
        srcValid = 2'b00; srcAbort = 2'b00;
        check("t3_words", 32'(wdCnt), 32'd4);
        check("t3_resets", 32'(pr), 32'd1);
        check("t3_drop_count", 32'(drop_count), 32'd2);

        // sync loss with an empty frame, then with six words written
        tick(); tick();
        srcValid = 2'b01;
        for (int c = 0; c < 10 && grant == 2'b00; c++) tick();
        check("t4_grant_a", 32'(grant), 32'h1);
        sync = 1'b0; pr = 0; gsum = 2'b00;
        repeat (5) begin
            tick();
            if (PacketReset) pr++;
            gsum = gsum | grant;
        end
        check("t4_empty_noreset", 32'(pr), 32'd0);
        check("t4_no_grant_low", 32'(gsum), 32'h0);
        check("t4_drop_same", 32'(drop_count), 32'd2);
        sync = 1'b1;
        for (int c = 0; c < 10 && grant == 2'b00; c++) tick();
        check("t4_grant_b", 32'(grant), 32'h1);
        wdCnt = 0;
        for (int c = 0; c < 20 && wdCnt < 6; c++) begin
            tick();
            if (WdAvail) wdCnt++;
        end
        sync = 1'b0; pr = 0;
        repeat (6) begin
            tick();
            if (PacketReset) pr++;
        end
        check("t4_partial_reset", 32'(pr), 32'd1);
        check("t4_drop_count", 32'(drop_count), 32'd3);
        srcValid = 2'b00; sync = 1'b1;
        repeat (3) tick();

`ifdef PACK_ARB_TAG_EN
        // Only src1 active: headers carry src id 1 and the frame sequence number
        srcValid = 2'b10; nh = 0; prevG = grant;
        for (int c = 0; c < 100 && nh < 3; c++) begin
            tick();
            if (grant != 2'b00 && prevG == 2'b00) begin
                hdr[nh] = WdAvail ? PacketWd : 16'h0000;
                nh++;
            end
            prevG = grant;
        end
        check("t6_hdr0", 32'(hdr[0]), 32'h0000F100);
        check("t6_hdr2", 32'(hdr[2]), 32'h0000F102);
        repeat (10) tick();
        srcValid = 2'b00;
        repeat (TIMEOUT + 5) tick();
`endif

        // Randomized traffic, checked entirely by the reference model
        for (int c = 0; c < 3000; c++) begin
            sync = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 31) == 0) quiet = 2'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                srcValid[i] = !quiet[i] && ($urandom_range(0, 3) != 0);
                srcAbort[i] = ($urandom_range(0, 47) == 0);
            end
            tick();
        end
        srcValid = 2'b00; srcAbort = 2'b00; sync = 1'b1;
        repeat (TIMEOUT + 5) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
